// File: rtl/tuner_pkg.sv
// Shared constants and elaboration-time helpers for the I/Q tuner.
package tuner_pkg;

  localparam int         LAT      = 6;
  localparam logic [1:0] QOFS_COS = 2'd1;
  localparam logic [1:0] QOFS_SIN = 2'd0;
  localparam string      LUT_INIT_FILE = "sincos_lut_q.hex";

  function automatic int rnd_shift(input int dsz, input int csz, input int osz);
    return dsz + csz - 1 - osz;
  endfunction

  // round((2^(csz-1)-1) * sin(pi/2*(k+0.5)/2^lsz)) via a Q60 Taylor series
  function automatic int lut_entry(input int k, input int lsz, input int csz);
    logic [127:0] x, x2, term, sum, amp;
    x    = (128'h3243F6A8885A308D * 128'(2 * k + 1)) >> (lsz + 2);
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'(2 * n * (2 * n + 1));
      if ((n % 2) == 1) sum = sum - term;
      else              sum = sum + term;
    end
    amp = 128'(2 ** (csz - 1) - 1);
    return int'((sum * amp + (128'd1 << 59)) >> 60);
  endfunction

endpackage

// File: rtl/sincos_lut_q.sv
// Quarter-wave sin/cos ROM: mirrors and signs the table per quadrant and leg.
module sincos_lut_q
  import tuner_pkg::*;
#(
  parameter int LSZ = 10,
  parameter int CSZ = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LSZ+1:0]        phase,
  input  logic                  leg_q,
  output logic signed [CSZ-1:0] coef
);

  logic [CSZ-1:0]        rom [2**LSZ];
  logic [1:0]            quad;
  logic [LSZ-1:0]        addr;
  logic [LSZ-1:0]        addr_reg;
  logic                  neg_reg;
  logic                  neg_d_reg;
  logic signed [CSZ-1:0] data_reg;

  for (genvar gi = 0; gi < 2**LSZ; gi++) begin : g_rom
    localparam int VAL = lut_entry(gi, LSZ, CSZ);
    assign rom[gi] = CSZ'(VAL);
  end

  always_comb begin
    quad = phase[LSZ+1:LSZ] + (leg_q ? QOFS_SIN : QOFS_COS);
    addr = phase[LSZ-1:0] ^ {LSZ{quad[0]}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      neg_reg   <= 1'b0;
      neg_d_reg <= 1'b0;
    end else begin
      addr_reg  <= addr;
      neg_reg   <= quad[1] ^ leg_q;
      neg_d_reg <= neg_reg;
    end
  end

  always_ff @(posedge clk) begin
    data_reg <= $signed(rom[addr_reg]);
  end

  // Table peak is 2^(CSZ-1)-1, so negation cannot overflow.
  assign coef = neg_d_reg ? -data_reg : data_reg;

endmodule

// File: rtl/tuner_iq_nco.sv
// Complex down-conversion tuner: real sample in, I/Q pair out every 2 clocks.
// One NCO, one quarter-wave ROM and one multiplier are shared by both legs.
module tuner_iq_nco
  import tuner_pkg::*;
#(
  parameter int DSZ = 10,
  parameter int OSZ = 12,
  parameter int PSZ = 26,
  parameter int LSZ = 10,
  parameter int CSZ = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DSZ-1:0] in,
  input  logic        [PSZ-1:0] freq,
  input  logic                  phs_clr,
  output logic                  out_valid,
  output logic signed [OSZ-1:0] out_i,
  output logic signed [OSZ-1:0] out_q,
  output logic                  sat_flag
);

  localparam int PW = DSZ + CSZ;
  localparam int S  = rnd_shift(DSZ, CSZ, OSZ);
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (S - 1));
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (OSZ - 1) - 1);
  localparam logic signed [PW-1:0] MINV = -PW'(2 ** (OSZ - 1));

  logic                  accept;
  logic [PSZ-1:0]        acc_reg;
  logic [LSZ+1:0]        theta_reg;
  logic signed [DSZ-1:0] samp_reg, samp_d1_reg, samp_d2_reg;
  logic [LAT-1:0]        vld_reg;
  logic signed [CSZ-1:0] coef;
  logic signed [PW-1:0]  prod_reg;
  logic signed [PW-1:0]  rnd;
  logic signed [OSZ-1:0] res, res_reg, i_hold_reg;
  logic                  res_clip, res_clip_reg, i_clip_reg;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      acc_reg   <= '0;
      theta_reg <= '0;
      samp_reg  <= '0;
    end else begin
      in_ready <= ~accept;
      if (accept) begin
        theta_reg <= acc_reg[PSZ-1 -: LSZ+2];
        samp_reg  <= in;
      end
      if (phs_clr)     acc_reg <= '0;
      else if (accept) acc_reg <= acc_reg + freq;
    end
  end

  // vld_reg[k] marks a sample accepted k+1 edges ago; the I leg is issued
  // the cycle after accept, the Q leg one cycle later.
  sincos_lut_q #(.LSZ(LSZ), .CSZ(CSZ)) u_lut (
    .clk   (clk),
    .reset (reset),
    .phase (theta_reg),
    .leg_q (~vld_reg[0]),
    .coef  (coef)
  );

  always_comb begin
    rnd      = (prod_reg + HALF) >>> S;
    res      = rnd[OSZ-1:0];
    res_clip = 1'b0;
    if (rnd > MAXV) begin
      res      = MAXV[OSZ-1:0];
      res_clip = 1'b1;
    end else if (rnd < MINV) begin
      res      = MINV[OSZ-1:0];
      res_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg      <= '0;
      samp_d1_reg  <= '0;
      samp_d2_reg  <= '0;
      prod_reg     <= '0;
      res_reg      <= '0;
      res_clip_reg <= 1'b0;
      i_hold_reg   <= '0;
      i_clip_reg   <= 1'b0;
    end else begin
      vld_reg      <= {vld_reg[LAT-2:0], accept};
      samp_d1_reg  <= samp_reg;
      samp_d2_reg  <= samp_d1_reg;
      prod_reg     <= PW'(samp_d2_reg) * PW'(coef);
      res_reg      <= res;
      res_clip_reg <= res_clip;
      // I result is parked here while the Q leg finishes.
      if (vld_reg[LAT-2]) begin
        i_hold_reg <= res_reg;
        i_clip_reg <= res_clip_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= vld_reg[LAT-1];
      if (vld_reg[LAT-1]) begin
        out_i    <= i_hold_reg;
        out_q    <= res_reg;
        sat_flag <= sat_flag | i_clip_reg | res_clip_reg;
      end
    end
  end

endmodule

// File: tb/tb_tuner_iq_nco.sv
// Scoreboard bench for tuner_iq_nco against a real-valued cos/sin reference.
module tb_tuner_iq_nco;

  localparam int  DSZ = 10;
  localparam int  OSZ = 12;
  localparam int  PSZ = 26;
  localparam int  LSZ = 10;
  localparam int  CSZ = 16;
  localparam real PI  = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  phs_clr = 1'b0;
  logic signed [DSZ-1:0] in_s = '0;
  logic        [PSZ-1:0] freq = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [OSZ-1:0] out_i;
  logic signed [OSZ-1:0] out_q;
  logic                  sat_flag;

  tuner_iq_nco #(.DSZ(DSZ), .OSZ(OSZ), .PSZ(PSZ), .LSZ(LSZ), .CSZ(CSZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_s),
    .freq      (freq),
    .phs_clr   (phs_clr),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  yi;
    int  yq;
    bit  sat;
    time t;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int             errors = 0;
  int             checks = 0;
  int             n_out = 0;
  logic [PSZ-1:0] m_acc = '0;
  bit             m_sat = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Table value of a unit-circle component, rounded on magnitude.
  function automatic int q16(input real v);
    real a;
    int  m;
    a = (v < 0.0) ? -v : v;
    m = $rtoi(real'(2 ** (CSZ - 1) - 1) * a + 0.5);
    return (v < 0.0) ? -m : m;
  endfunction

  function automatic int scale(input longint prod, output bit clip);
    real y;
    y = $floor((real'(prod) + 4096.0) / 8192.0);
    clip = 1'b0;
    if (y > 2047.0) begin
      y = 2047.0;
      clip = 1'b1;
    end else if (y < -2048.0) begin
      y = -2048.0;
      clip = 1'b1;
    end
    return $rtoi(y);
  endfunction

  task automatic push_expect(input int d, input logic [PSZ-1:0] th);
    int   p;
    real  ang;
    bit   ci, cq;
    exp_t e;
    p   = int'(th >> (PSZ - LSZ - 2));
    ang = 2.0 * PI * (real'(p) + 0.5) / real'(2 ** (LSZ + 2));
    e.yi = scale(longint'(d) * longint'(q16($cos(ang))), ci);
    e.yq = scale(-(longint'(d) * longint'(q16($sin(ang)))), cq);
    m_sat = m_sat | ci | cq;
    e.sat = m_sat;
    e.t   = $time + 60;
    sb.push_back(e);
  endtask

  task automatic send(input int d, input logic [PSZ-1:0] f, input bit clr);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", longint'(in_ready), 1);
    if (!in_ready) return;
    in_s     = d[DSZ-1:0];
    freq     = f;
    phs_clr  = clr;
    in_valid = 1'b1;
    @(posedge clk);
    push_expect(d, m_acc);
    m_acc = clr ? '0 : m_acc + f;
    @(negedge clk);
    in_valid = 1'b0;
    phs_clr  = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    phs_clr = 1'b1;
    @(negedge clk);
    phs_clr = 1'b0;
    m_acc = '0;
  endtask

  // in_valid held high; the producer only changes data after an accept.
  task automatic stream(input int cycles);
    bit rdy;
    int d;
    rdy = 1'b1;
    d = 0;
    freq = PSZ'($urandom);
    @(negedge clk);
    in_valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      check("in_ready_stream", longint'(in_ready), longint'(rdy));
      if (rdy) begin
        d = int'($urandom_range(0, 1023)) - 512;
        in_s = d[DSZ-1:0];
      end
      @(posedge clk);
      if (rdy) begin
        push_expect(d, m_acc);
        m_acc = m_acc + freq;
      end
      rdy = !rdy;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      $display("out %0d: i=%0d q=%0d sat=%0b t=%0t", n_out, out_i, out_q, sat_flag, $time);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_i=%0d out_q=%0d, expected no output", out_i, out_q);
      end else begin
        mon_e = sb.pop_front();
        check("out_i", longint'(out_i), longint'(mon_e.yi));
        check("out_q", longint'(out_q), longint'(mon_e.yq));
        check("sat_flag", longint'(sat_flag), longint'(mon_e.sat));
        check("latency", longint'($time) - 5, longint'(mon_e.t));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_i", longint'(out_i), 0);
    check("rst_out_q", longint'(out_q), 0);
    check("rst_sat_flag", longint'(sat_flag), 0);
    check("rst_in_ready", longint'(in_ready), 1);

    // Static phase
    clr_pulse();
    for (int k = 0; k < 3; k++) send(100, '0, 1'b0);

    // Quarter-rate sweep
    for (int k = 0; k < 8; k++) send(511, PSZ'(2 ** 24), 1'b0);

    // Saturation at theta = pi, then sticky flag
    clr_pulse();
    send(-512, PSZ'(2 ** 25), 1'b0);
    send(-512, PSZ'(2 ** 25), 1'b0);
    send(3, '0, 1'b0);

    // Throughput with in_valid held
    stream(20);

    // phs_clr coinciding with an accept
    send(100, 26'h2AAAAAA, 1'b0);
    send(100, PSZ'(2 ** 23), 1'b1);
    send(100, '0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(int'($urandom_range(0, 1023)) - 512, PSZ'($urandom), $urandom_range(0, 7) == 0);
    end

    // Reset three cycles after an accept
    send(77, 26'h1234567, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_acc = '0;
    m_sat = 1'b0;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_i", longint'(out_i), 0);
    check("mid_rst_out_q", longint'(out_q), 0);
    check("mid_rst_sat_flag", longint'(sat_flag), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    repeat (8) @(negedge clk);
    send(100, '0, 1'b0);

    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check("drain", longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
